// File: rtl/phrase_player_if.sv
// Note stream from phrase_player to a tone consumer, with status flags.
// master = player side, slave = consumer side.
interface phrase_player_if #(
  parameter int NOTE_W = 6
);
  logic [NOTE_W-1:0] note_out;
  logic              note_valid;
  logic              note_ready;
  logic [3:0]        index;
  logic              busy;
  logic              done;

  modport master (
    output note_out, note_valid, index, busy, done,
    input  note_ready
  );

  modport slave (
    input  note_out, note_valid, index, busy, done,
    output note_ready
  );
endinterface

// File: rtl/phrase_player.sv
// Plays a 16-note snapshot oldest-first, one note per beat, with a BEAT_CYCLES gap between notes.
// Latency: first note valid 1 cycle after start; note_valid holds under backpressure; outputs registered.
module phrase_player #(
  parameter int NOTE_W      = 6,
  parameter int BEAT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NOTE_W-1:0] n0,
  input  logic [NOTE_W-1:0] n1,
  input  logic [NOTE_W-1:0] n2,
  input  logic [NOTE_W-1:0] n3,
  input  logic [NOTE_W-1:0] n4,
  input  logic [NOTE_W-1:0] n5,
  input  logic [NOTE_W-1:0] n6,
  input  logic [NOTE_W-1:0] n7,
  input  logic [NOTE_W-1:0] n8,
  input  logic [NOTE_W-1:0] n9,
  input  logic [NOTE_W-1:0] n10,
  input  logic [NOTE_W-1:0] n11,
  input  logic [NOTE_W-1:0] n12,
  input  logic [NOTE_W-1:0] n13,
  input  logic [NOTE_W-1:0] n14,
  input  logic [NOTE_W-1:0] n15,
  input  logic              buffer_full,
  input  logic              start,
  input  logic              abort,
  phrase_player_if.master   play
);

  typedef enum logic [1:0] {IDLE, EMIT, GAP, DONE} state_t;

  localparam logic [15:0] GAP_LOAD = 16'(BEAT_CYCLES - 1);

  state_t            state;
  logic [NOTE_W-1:0] phrase [16];
  logic [NOTE_W-1:0] snap   [16];
  logic [15:0]       gap_cnt;
  logic [3:0]        index_q;
  logic [3:0]        next_index;
  logic [NOTE_W-1:0] note_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;
  logic              take;
  logic              transfer;

  // Playback position k carries n(15-k): position 0 is the oldest note.
  assign phrase[0]  = n15;
  assign phrase[1]  = n14;
  assign phrase[2]  = n13;
  assign phrase[3]  = n12;
  assign phrase[4]  = n11;
  assign phrase[5]  = n10;
  assign phrase[6]  = n9;
  assign phrase[7]  = n8;
  assign phrase[8]  = n7;
  assign phrase[9]  = n6;
  assign phrase[10] = n5;
  assign phrase[11] = n4;
  assign phrase[12] = n3;
  assign phrase[13] = n2;
  assign phrase[14] = n1;
  assign phrase[15] = n0;

  assign next_index = index_q + 4'd1;
  assign take       = (state == IDLE) && start && buffer_full;
  assign transfer   = valid_q && play.note_ready;

  // Snapshot is pure data, so it needs no reset; it only loads on an accepted start.
  always_ff @(posedge clk) begin
    if (!reset && !abort && take) begin
      for (int k = 0; k < 16; k++) begin
        snap[k] <= phrase[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      state   <= IDLE;
      note_q  <= '0;
      valid_q <= 1'b0;
      index_q <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      gap_cnt <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (take) begin
            state   <= EMIT;
            index_q <= 4'd0;
            note_q  <= phrase[0];
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        EMIT: begin
          if (transfer) begin
            valid_q <= 1'b0;
            note_q  <= '0;
            if (index_q == 4'd15) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state   <= GAP;
              gap_cnt <= GAP_LOAD;
            end
          end
        end
        GAP: begin
          if (gap_cnt == 16'd0) begin
            state   <= EMIT;
            index_q <= next_index;
            note_q  <= snap[next_index];
            valid_q <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end
        DONE: begin
          state   <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          index_q <= 4'd0;
        end
        default: begin
          state   <= IDLE;
          note_q  <= '0;
          valid_q <= 1'b0;
          index_q <= 4'd0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign play.note_out   = note_q;
  assign play.note_valid = valid_q;
  assign play.index      = index_q;
  assign play.busy       = busy_q;
  assign play.done       = done_q;

endmodule

// File: tb/tb_phrase_player.sv
// Directed bench for phrase_player: one DUT with a 4-cycle beat gap, one with the minimum 1-cycle gap.
module tb_phrase_player;

  logic       clk = 1'b0;
  logic       reset;
  logic       buffer_full;
  logic       start_a;
  logic       start_b;
  logic       abort;
  logic [5:0] n [16];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  phrase_player_if #(.NOTE_W(6)) ifa ();
  phrase_player_if #(.NOTE_W(6)) ifb ();

  phrase_player #(.NOTE_W(6), .BEAT_CYCLES(4)) dut_a (
    .clk(clk), .reset(reset),
    .n0(n[0]), .n1(n[1]), .n2(n[2]), .n3(n[3]), .n4(n[4]), .n5(n[5]), .n6(n[6]), .n7(n[7]),
    .n8(n[8]), .n9(n[9]), .n10(n[10]), .n11(n[11]), .n12(n[12]), .n13(n[13]), .n14(n[14]), .n15(n[15]),
    .buffer_full(buffer_full), .start(start_a), .abort(abort), .play(ifa)
  );

  phrase_player #(.NOTE_W(6), .BEAT_CYCLES(1)) dut_b (
    .clk(clk), .reset(reset),
    .n0(n[0]), .n1(n[1]), .n2(n[2]), .n3(n[3]), .n4(n[4]), .n5(n[5]), .n6(n[6]), .n7(n[7]),
    .n8(n[8]), .n9(n[9]), .n10(n[10]), .n11(n[11]), .n12(n[12]), .n13(n[13]), .n14(n[14]), .n15(n[15]),
    .buffer_full(buffer_full), .start(start_b), .abort(abort), .play(ifb)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // n15 (oldest) = 1 ... n0 (newest) = 16, so playback order is 1..16.
  task automatic load_notes;
    for (int i = 0; i < 16; i++) n[i] = 6'(16 - i);
  endtask

  task automatic test_reset;
    load_notes();
    buffer_full = 1'b1;
    ifa.note_ready = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    compared++;
    if (ifa.note_valid !== 1'b1) begin
      mismatched++; $display("FAIL reset_pre_valid got %b want 1", ifa.note_valid);
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    compared++;
    if (ifa.note_out !== 6'd0) begin
      mismatched++; $display("FAIL reset_note_out got %0d want 0", ifa.note_out);
    end
    compared++;
    if (ifa.note_valid !== 1'b0) begin
      mismatched++; $display("FAIL reset_note_valid got %b want 0", ifa.note_valid);
    end
    compared++;
    if (ifa.index !== 4'd0) begin
      mismatched++; $display("FAIL reset_index got %0d want 0", ifa.index);
    end
    compared++;
    if (ifa.busy !== 1'b0) begin
      mismatched++; $display("FAIL reset_busy got %b want 0", ifa.busy);
    end
    compared++;
    if (ifa.done !== 1'b0) begin
      mismatched++; $display("FAIL reset_done got %b want 0", ifa.done);
    end
    buffer_full = 1'b0;
    start_a = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      compared++;
      if (ifa.busy !== 1'b0) begin
        mismatched++; $display("FAIL start_not_full_busy cyc %0d got %b want 0", c, ifa.busy);
      end
      compared++;
      if (ifa.note_valid !== 1'b0) begin
        mismatched++; $display("FAIL start_not_full_valid cyc %0d got %b want 0", c, ifa.note_valid);
      end
    end
    start_a = 1'b0;
    buffer_full = 1'b1;
    tick();
  endtask

  // Shared by full playback and snapshot tests: note_ready high, start in cycle 0.
  task automatic run_phrase_a(input bit disturb);
    logic       exp_valid;
    logic [5:0] exp_note;
    logic [3:0] exp_idx;
    load_notes();
    buffer_full = 1'b1;
    ifa.note_ready = 1'b1;
    start_a = 1'b1;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      tick();
      start_a = 1'b0;
      if (disturb && cyc == 12) begin
        for (int i = 0; i < 16; i++) n[i] = 6'd63;
        start_a = 1'b1;
      end
      exp_valid = (cyc <= 76) && (((cyc - 1) % 5) == 0);
      exp_note  = exp_valid ? 6'((cyc - 1) / 5 + 1) : 6'd0;
      exp_idx   = (cyc <= 77) ? 4'((cyc - 1) / 5) : 4'd0;
      compared++;
      if (ifa.note_valid !== exp_valid) begin
        mismatched++; $display("FAIL play%0d_valid cyc %0d got %b want %b", disturb, cyc, ifa.note_valid, exp_valid);
      end
      compared++;
      if (ifa.note_out !== exp_note) begin
        mismatched++; $display("FAIL play%0d_note cyc %0d got %0d want %0d", disturb, cyc, ifa.note_out, exp_note);
      end
      compared++;
      if (ifa.index !== exp_idx) begin
        mismatched++; $display("FAIL play%0d_index cyc %0d got %0d want %0d", disturb, cyc, ifa.index, exp_idx);
      end
      compared++;
      if (ifa.busy !== (cyc <= 77)) begin
        mismatched++; $display("FAIL play%0d_busy cyc %0d got %b want %b", disturb, cyc, ifa.busy, (cyc <= 77));
      end
      compared++;
      if (ifa.done !== (cyc == 77)) begin
        mismatched++; $display("FAIL play%0d_done cyc %0d got %b want %b", disturb, cyc, ifa.done, (cyc == 77));
      end
    end
    start_a = 1'b0;
    load_notes();
  endtask

  task automatic test_full_playback;
    run_phrase_a(1'b0);
  endtask

  task automatic test_snapshot;
    run_phrase_a(1'b1);
  endtask

  task automatic test_backpressure;
    load_notes();
    ifa.note_ready = 1'b0;
    start_a = 1'b1;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      tick();
      start_a = 1'b0;
      if (cyc == 4) ifa.note_ready = 1'b1;
      if (cyc <= 4) begin
        compared++;
        if (ifa.note_valid !== 1'b1 || ifa.note_out !== 6'd1 || ifa.index !== 4'd0) begin
          mismatched++;
          $display("FAIL bp_hold cyc %0d got v=%b note=%0d idx=%0d want v=1 note=1 idx=0",
                   cyc, ifa.note_valid, ifa.note_out, ifa.index);
        end
      end else if (cyc <= 8) begin
        compared++;
        if (ifa.note_valid !== 1'b0) begin
          mismatched++; $display("FAIL bp_gap cyc %0d got %b want 0", cyc, ifa.note_valid);
        end
      end else begin
        compared++;
        if (ifa.note_valid !== 1'b1 || ifa.note_out !== 6'd2 || ifa.index !== 4'd1) begin
          mismatched++;
          $display("FAIL bp_second cyc %0d got v=%b note=%0d idx=%0d want v=1 note=2 idx=1",
                   cyc, ifa.note_valid, ifa.note_out, ifa.index);
        end
      end
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    compared++;
    if (ifa.busy !== 1'b0) begin
      mismatched++; $display("FAIL bp_cleanup_busy got %b want 0", ifa.busy);
    end
  endtask

  task automatic test_abort;
    bit saw_activity;
    load_notes();
    ifa.note_ready = 1'b1;
    start_a = 1'b1;
    for (int cyc = 1; cyc <= 22; cyc++) begin
      tick();
      start_a = 1'b0;
      if (cyc == 21) begin
        compared++;
        if (ifa.note_valid !== 1'b1 || ifa.note_out !== 6'd5) begin
          mismatched++; $display("FAIL abort_note5 got v=%b note=%0d want v=1 note=5", ifa.note_valid, ifa.note_out);
        end
      end
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    compared++;
    if (ifa.busy !== 1'b0) begin
      mismatched++; $display("FAIL abort_busy got %b want 0", ifa.busy);
    end
    compared++;
    if (ifa.index !== 4'd0) begin
      mismatched++; $display("FAIL abort_index got %0d want 0", ifa.index);
    end
    compared++;
    if (ifa.note_valid !== 1'b0 || ifa.done !== 1'b0) begin
      mismatched++; $display("FAIL abort_valid_done got v=%b d=%b want 0 0", ifa.note_valid, ifa.done);
    end
    saw_activity = 1'b0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (ifa.done !== 1'b0 || ifa.note_valid !== 1'b0) saw_activity = 1'b1;
    end
    compared++;
    if (saw_activity !== 1'b0) begin
      mismatched++; $display("FAIL abort_quiet got %b want 0", saw_activity);
    end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    compared++;
    if (ifa.note_valid !== 1'b1 || ifa.note_out !== 6'd1 || ifa.index !== 4'd0) begin
      mismatched++;
      $display("FAIL abort_replay got v=%b note=%0d idx=%0d want v=1 note=1 idx=0",
               ifa.note_valid, ifa.note_out, ifa.index);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  task automatic test_min_gap;
    logic       exp_valid;
    logic [5:0] exp_note;
    load_notes();
    ifb.note_ready = 1'b1;
    start_b = 1'b1;
    for (int cyc = 1; cyc <= 33; cyc++) begin
      tick();
      start_b = 1'b0;
      exp_valid = (cyc <= 31) && ((cyc % 2) == 1);
      exp_note  = exp_valid ? 6'((cyc + 1) / 2) : 6'd0;
      compared++;
      if (ifb.note_valid !== exp_valid) begin
        mismatched++; $display("FAIL min_valid cyc %0d got %b want %b", cyc, ifb.note_valid, exp_valid);
      end
      compared++;
      if (ifb.note_out !== exp_note) begin
        mismatched++; $display("FAIL min_note cyc %0d got %0d want %0d", cyc, ifb.note_out, exp_note);
      end
      compared++;
      if (ifb.done !== (cyc == 32)) begin
        mismatched++; $display("FAIL min_done cyc %0d got %b want %b", cyc, ifb.done, (cyc == 32));
      end
      compared++;
      if (ifb.busy !== (cyc <= 32)) begin
        mismatched++; $display("FAIL min_busy cyc %0d got %b want %b", cyc, ifb.busy, (cyc <= 32));
      end
    end
  endtask

  // Continues from the first IDLE cycle after test_min_gap's DONE.
  task automatic test_back_to_back;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    compared++;
    if (ifb.note_valid !== 1'b1 || ifb.note_out !== 6'd1 || ifb.busy !== 1'b1) begin
      mismatched++;
      $display("FAIL b2b_restart got v=%b note=%0d busy=%b want v=1 note=1 busy=1",
               ifb.note_valid, ifb.note_out, ifb.busy);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    buffer_full = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    abort = 1'b0;
    ifa.note_ready = 1'b0;
    ifb.note_ready = 1'b0;
    for (int i = 0; i < 16; i++) n[i] = 6'd0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    test_reset();
    test_full_playback();
    test_backpressure();
    test_snapshot();
    test_abort();
    test_min_gap();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/phrase_player.md
# phrase_player

Read-side counterpart of the 16-note phrase capture buffer. On a `start` request with a full buffer, the block snapshots the 16 captured notes. It then plays them out oldest-first to a downstream consumer (synth/tone generator), one note per beat, over a valid/ready handshake. A programmable beat gap separates notes, and a one-cycle `done` pulse marks the end of the phrase.

## Interface
- `NOTE_W`, 6: width of one note code.
- `BEAT_CYCLES`, 16: idle cycles inserted after each accepted note (legal range 1..65535); gap counter is 16 bits.
- Ports are listed with clock and reset first.
- `clk`, input, 1: the single clock.
- `reset`, input, 1: synchronous, active-high reset.
- `n0`..`n15`, input, NOTE_W each: captured phrase. `n0` is the newest note and `n15` is the oldest.
- `buffer_full`, input, 1: phrase holds 16 valid notes.
- `start`, input, 1: request playback; sampled only in IDLE.
- `abort`, input, 1: cancel playback.
- `note_ready`, input, 1: consumer accepts `note_out` this cycle.
- `note_out`, output, NOTE_W: current note.
- `note_valid`, output, 1: `note_out` is valid.
- `index`, output, 4: playback position 0..15. Position k carries snapshot of `n(15-k)`.
- `busy`, output, 1: state is not IDLE.
- `done`, output, 1: one-cycle pulse after the 16th note is accepted.

## Operation
- States: IDLE, EMIT, GAP, DONE.
- **IDLE**
  - If `start && buffer_full`: capture `n0`..`n15` into a 16×NOTE_W snapshot, set index=0, go to EMIT.
  - Otherwise stay in IDLE.
- **EMIT**
  - `note_valid`=1 and `note_out`=snapshot[index].
  - Transfer occurs when `note_valid && note_ready`. Without a transfer, state, `note_out` and `index` hold.
  - On transfer with index<15: go to GAP and load the gap counter with BEAT_CYCLES-1.
  - On transfer with index=15: go to DONE.
- **GAP**
  - `note_valid`=0. Counter decrements each cycle.
  - When counter=0: index increments and state goes to EMIT.
  - GAP lasts exactly BEAT_CYCLES cycles.
- **DONE**
  - `done`=1 for exactly one cycle, then IDLE with index=0.
- **Output rules**
  - `note_out`=0 whenever `note_valid`=0.
  - `busy`=1 in EMIT, GAP and DONE.
- **Snapshot isolation**: changes on `n0`..`n15` or `buffer_full` after the start cycle do not affect playback.
- **Start rules**: `start` is ignored outside IDLE. `start` with `buffer_full`=0 is ignored and produces no error.
- **Abort**: `abort` in any state sends the block to IDLE next cycle. It clears index and `note_valid`, and no `done` pulse is produced.
  - If a transfer coincides with `abort`, the consumer has taken that note, but the phrase still terminates with no `done`.
- **Priority**: `reset` > `abort` > handshake/start.

## Timing
- **Reset values**: state IDLE, `note_out`=0, `note_valid`=0, `index`=0, `busy`=0, `done`=0, gap counter=0. Reset mid-playback behaves the same as abort.
- **Outputs are registered**: all outputs change only on a clock edge, and none depends combinationally on `note_ready`.
- **Start latency**: `start` accepted at edge t gives `note_valid`=1 in cycle t+1.
- **Note spacing** with `note_ready` held high: consecutive `note_valid` assertions are BEAT_CYCLES+1 cycles apart.
- **Per-note latency**: extra cycles spent with `note_ready`=0 add 1:1 to the spacing.
- **Phrase length**: with `note_ready` held high, total phrase = 16 EMIT cycles + 15×BEAT_CYCLES gap cycles. `done` follows in the cycle after the 16th transfer, and `busy` drops the cycle after `done`.
- **Back-to-back**: a new `start` is accepted in the first IDLE cycle after DONE.

## Test plan
- **Reset**: assert `reset` mid-EMIT with note_valid=1 → next cycle all outputs at reset values. Then hold `start`=1 with `buffer_full`=0 → stays IDLE, `busy`=0.
- **Full playback**: BEAT_CYCLES=4, n15..n0 = 1..16, `note_ready`=1, `start` pulsed at cycle 0.
  - `note_valid` high at cycles 1, 6, 11, …, 76, with `note_out` = 1, 2, …, 16 and `index` = 0..15.
  - `done` high at cycle 77 only; `busy` low from cycle 78.
- **Backpressure**: hold `note_ready`=0 for 3 cycles during the first EMIT → `note_out`=1 and `note_valid`=1 held stable for 4 cycles. Transfer occurs on the 4th cycle, and the second note is delayed by 3 cycles.
- **Snapshot and start-while-busy**: overwrite all `n*` with 63 and pulse `start` during GAP after note 3 → remaining notes are still 4..16, and no restart occurs.
- **Abort**: assert `abort` during GAP after note 5 → next cycle IDLE, `busy`=0, `index`=0, and no `done`. A following `start` replays from note 1.
- **Minimum gap**: BEAT_CYCLES=1, `note_ready`=1 → `note_valid` pulses every 2 cycles and `done` arrives 32 cycles after `start`.
